// File: rtl/biquad_coeff_loader.sv
// Wishbone master that copies biquad8 coefficients from a local RAM
// into each enabled notch stage of the trigger chain, then pulses update.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   start_i, bq_mask_i   load request and per-stage enable
//   busy_o, done_o       sequence in progress / end-of-sequence pulse
//   err_o                sticky ack-timeout flag
//   coef_addr_o/dat_i    coefficient RAM read port (1-cycle latency)
//   wb_*                 Wishbone master write port
module biquad_coeff_loader #(
  parameter int          NUM_BQ      = 2,
  parameter logic [7:0]  BQ_STRIDE   = 8'h80,
  parameter int          COEF_PER_BQ = 25,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          CADDR_W     = 6
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [NUM_BQ-1:0]  bq_mask_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CADDR_W-1:0] coef_addr_o,
  input  logic [31:0]        coef_dat_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o,
  output logic [7:0]         wb_adr_o,
  output logic [31:0]        wb_dat_o,
  input  logic               wb_ack_i
);

  localparam int SW = $clog2(NUM_BQ + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_FETCH, S_RDWAIT,
    S_WRITE, S_UPD, S_DONE
  } state_t;

  state_t            r_state;
  logic [NUM_BQ-1:0] r_mask;
  logic [SW-1:0]     r_stage;
  logic [4:0]        r_idx;
  logic [7:0]        r_to;
  logic              r_stb;
  logic [7:0]        r_adr;
  logic [31:0]       r_dat;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [7:0]        w_base;
  logic [SW-1:0]     w_next;
  logic              w_found;
  logic              w_last;
  logic              w_to_hit;

  // Register offset inside a stage for coefficient word idx.
  function automatic logic [7:0] off(input logic [4:0] idx);
    if (idx <= 5'd1)       off = 8'h04;
    else if (idx <= 5'd5)  off = 8'h08;
    else if (idx <= 5'd7)  off = 8'h0C;
    else if (idx <= 5'd14) off = 8'h10;
    else if (idx <= 5'd22) off = 8'h14;
    else if (idx == 5'd23) off = 8'h18;
    else                   off = 8'h1C;
  endfunction

  assign w_base   = 8'(int'(r_stage) * int'(BQ_STRIDE));
  assign w_last   = (r_idx == 5'(COEF_PER_BQ - 1));
  assign w_to_hit = (r_to == 8'(ACK_TIMEOUT - 1));

  assign coef_addr_o =
    CADDR_W'(int'(r_stage) * COEF_PER_BQ + int'(r_idx));

  // Lowest enabled stage at or above the current one.
  always_comb begin
    w_found = 1'b0;
    w_next  = r_stage;
    for (int i = NUM_BQ - 1; i >= 0; i--) begin
      if (i >= int'(r_stage) && r_mask[i]) begin
        w_found = 1'b1;
        w_next  = SW'(i);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_stage <= '0;
      r_idx   <= '0;
      r_to    <= '0;
      r_stb   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mask  <= bq_mask_i;
            r_err   <= 1'b0;
            r_stage <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SEL;
          end
        end
        S_SEL: begin
          if (w_found) begin
            r_stage <= w_next;
            r_idx   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_FETCH: r_state <= S_RDWAIT;
        S_RDWAIT: begin
          r_dat   <= coef_dat_i;
          r_adr   <= w_base + off(r_idx);
          r_stb   <= 1'b1;
          r_to    <= '0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (wb_ack_i) begin
            r_stb <= 1'b0;
            if (w_last) begin
              r_state <= S_UPD;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_FETCH;
            end
          end else if (w_to_hit) begin
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to <= r_to + 8'd1;
          end
        end
        S_UPD: begin
          // First cycle raises the strobe; later cycles wait for ack.
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_adr <= w_base;
            r_dat <= 32'd1;
            r_to  <= '0;
          end else if (wb_ack_i) begin
            r_stb   <= 1'b0;
            r_stage <= r_stage + SW'(1);
            r_state <= S_SEL;
          end else if (w_to_hit) begin
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to <= r_to + 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign err_o    = r_err;
  assign wb_cyc_o = r_stb;
  assign wb_stb_o = r_stb;
  assign wb_we_o  = r_stb;
  assign wb_sel_o = {4{r_stb}};
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Bench for biquad_coeff_loader: RAM model, Wishbone slave model
// and a write scoreboard fed when each load is started.
module tb_biquad_coeff_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mask;
  logic        busy, done, err;
  logic [5:0]  caddr;
  logic [31:0] ram_q;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] dat;
  logic        ack, s_ack, f_ack;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } tr_t;

  tr_t q[$];
  int  total = 0;
  int  bad = 0;
  int  wcount = 0;
  int  done_cnt = 0;
  int  blk = -1;
  int  run_len = 0;
  int  max_run = 0;
  bit  cyc_seen = 0;
  int  dc;

  logic [7:0] offs [25] = '{
    8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08, 8'h0C, 8'h0C,
    8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
    8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14,
    8'h18, 8'h1C};

  biquad_coeff_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .bq_mask_i  (mask),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .coef_addr_o(caddr),
    .coef_dat_i (ram_q),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_sel_o   (sel),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat),
    .wb_ack_i   (ack)
  );

  always #5 clk = ~clk;

  // RAM holds RAM[i] = i, one cycle read latency.
  always @(posedge clk) ram_q <= 32'(caddr);

  // Zero-wait slave; withholds ack for write number blk.
  always @(posedge clk) begin
    if (rst) s_ack <= 1'b0;
    else s_ack <= cyc && stb && !s_ack && (wcount != blk);
  end
  assign ack = s_ack | f_ack;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare each acked write against the scoreboard.
  always @(negedge clk) begin
    tr_t e;
    if (cyc) cyc_seen = 1;
    if (done) done_cnt++;
    if (stb && !ack) run_len++;
    else begin
      if (run_len > max_run) max_run = run_len;
      run_len = 0;
    end
    if (cyc && stb && ack) begin
      wcount++;
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.a = 'x;
        e.d = 'x;
      end
      chk("wb_adr", 32'(adr), 32'(e.a));
      chk("wb_dat", dat, e.d);
      chk("wb_sel_we", {27'd0, we, sel}, 32'h1F);
    end
  end

  task automatic push_stage(input int s, input int n);
    tr_t t;
    for (int i = 0; i < n; i++) begin
      t.a = 8'(s * 128) + offs[i];
      t.d = 32'(s * 25 + i);
      q.push_back(t);
    end
    if (n == 25) begin
      t.a = 8'(s * 128);
      t.d = 32'd1;
      q.push_back(t);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic new_run();
    wcount   = 0;
    done_cnt = 0;
    max_run  = 0;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    mask  = 2'b00;
    f_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_adr", 32'(adr), 0);
    chk("rst_dat", dat, 0);
    chk("rst_caddr", 32'(caddr), 0);
    rst = 1'b0;

    // Stray ack while idle.
    @(negedge clk) f_ack = 1'b1;
    @(negedge clk) f_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy), 0);
    chk("idle_ack_cyc", 32'(cyc), 0);

    // Both stages, with a stray start mid-sequence.
    new_run();
    push_stage(0, 25);
    push_stage(1, 25);
    pulse_start(2'b11);
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    while (wcount < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_w20", 32'(wcount >= 20), 1);
    pulse_start(2'b01);
    wait_done(2000);
    chk("full_wcount", 32'(wcount), 52);
    chk("full_q", 32'(q.size()), 0);
    chk("full_err", 32'(err), 0);
    chk("full_done_cnt", 32'(done_cnt), 1);
    chk("full_busy", 32'(busy), 0);

    // Stage 1 only.
    new_run();
    push_stage(1, 25);
    pulse_start(2'b10);
    wait_done(2000);
    chk("m10_wcount", 32'(wcount), 26);
    chk("m10_q", 32'(q.size()), 0);

    // Slave withholds ack on write 3.
    new_run();
    blk = 3;
    push_stage(0, 3);
    pulse_start(2'b01);
    wait_done(2000);
    @(negedge clk);
    chk("to_stb_len", 32'(max_run), 255);
    chk("to_err", 32'(err), 1);
    chk("to_cyc", 32'(cyc), 0);
    chk("to_wcount", 32'(wcount), 3);
    chk("to_q", 32'(q.size()), 0);
    chk("to_done_cnt", 32'(done_cnt), 1);
    blk = -1;

    // Good start clears err.
    new_run();
    push_stage(0, 25);
    pulse_start(2'b01);
    chk("err_cleared", 32'(err), 0);
    wait_done(2000);
    chk("rec_wcount", 32'(wcount), 26);
    chk("rec_q", 32'(q.size()), 0);

    // Reset during the write of idx 10.
    new_run();
    push_stage(0, 25);
    push_stage(1, 25);
    pulse_start(2'b11);
    n = 0;
    while (!(wcount >= 10 && cyc && !ack) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_w10", 32'(wcount), 10);
    rst = 1'b1;
    dc  = done_cnt;
    @(negedge clk);
    chk("mrst_cyc", 32'(cyc), 0);
    chk("mrst_stb", 32'(stb), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_no_done", 32'(done_cnt), 32'(dc));
    q.delete();
    new_run();
    push_stage(0, 25);
    push_stage(1, 25);
    pulse_start(2'b11);
    wait_done(2000);
    chk("replay_wcount", 32'(wcount), 52);
    chk("replay_q", 32'(q.size()), 0);

    // Empty mask.
    new_run();
    cyc_seen = 0;
    pulse_start(2'b00);
    chk("m0_done_c0", 32'(done), 0);
    @(negedge clk);
    chk("m0_done_c1", 32'(done), 0);
    @(negedge clk);
    chk("m0_done_c2", 32'(done), 1);
    chk("m0_busy_c2", 32'(busy), 0);
    @(negedge clk);
    chk("m0_no_cyc", 32'(cyc_seen), 0);
    chk("m0_wcount", 32'(wcount), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
